shift_normalizer: RTL

//  Inverse companion of the signed-amount shifter. Takes a 2N-bit product-width value and returns
//  an N-bit normalized value plus the signed shift amount that regenerates it:
//  in_data ~= out_data << out_shift, where out_shift < 0 means a right shift by -out_shift.

---
 rtl/shifter_pkg.sv | 16 +
 rtl/shift_normalizer_round.sv | 41 ++++
 rtl/shift_normalizer.sv | 103 ++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the normalizer: FSM state encoding and counter sizing.
// Optional rounding is selected by SHIFT_NORMALIZER_ROUND_EN.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // Leading-zero counter width for a 2n-bit input.
  function automatic int lz_width(input int n);
    return $clog2(2 * n) + 1;
  endfunction

endpackage

// File: rtl/shift_normalizer_round.sv
// Round-to-nearest-even stage applied when the leading one is found.
// Used only when SHIFT_NORMALIZER_ROUND_EN is defined.
module shift_normalizer_round
  import shifter_pkg::*;
#(
  parameter int N    = 8,
  parameter int LZ_W = lz_width(N)
) (
  input  logic [2*N-1:0] work,
  input  logic [LZ_W-1:0] lz,
  output logic [N-1:0]   out_data,
  output logic [N-1:0]   out_shift
);

  logic [N-1:0] hi;
  logic guard;
  logic sticky;
  logic inc;
  logic signed [LZ_W:0] shift_s;
  logic signed [LZ_W:0] shift_r;

  assign hi      = work[2*N-1:N];
  assign guard   = work[N-1];
  assign sticky  = |work[N-2:0];
  assign inc     = guard & (sticky | work[N]);
  assign shift_s = $signed((LZ_W+1)'(N))
                 - $signed({1'b0, lz});
  assign shift_r = shift_s
                 + $signed((LZ_W+1)'(1));

  // Carry out of an all-ones mantissa renormalizes by one place.
  always_comb begin
    out_data  = hi + N'(inc);
    out_shift = N'(shift_s);
    if (inc && (&hi)) begin
      out_data  = {1'b1, {(N-1){1'b0}}};
      out_shift = N'(shift_r);
    end
  end

endmodule

// File: rtl/shift_normalizer.sv
// Iterative normalizer: 2N-bit value -> N-bit mantissa plus signed shift.
// Define SHIFT_NORMALIZER_ROUND_EN for round-to-nearest-even instead of truncation.
module shift_normalizer
  import shifter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic [N-1:0]   out_shift,
  output logic           out_zero,
  output logic           busy
);

  localparam int LZ_W = lz_width(N);

  state_t          state;
  logic [2*N-1:0]  work;
  logic [LZ_W-1:0] lz;
  logic [N-1:0]    nxt_data;
  logic [N-1:0]    nxt_shift;

  assign in_ready = (state == IDLE) & ~rst;
  assign busy     = (state != IDLE);

`ifdef SHIFT_NORMALIZER_ROUND_EN
  shift_normalizer_round #(
    .N    (N),
    .LZ_W (LZ_W)
  ) u_round (
    .work      (work),
    .lz        (lz),
    .out_data  (nxt_data),
    .out_shift (nxt_shift)
  );
`else
  logic signed [LZ_W:0] shift_s;
  logic unused_low;

  assign shift_s    = $signed((LZ_W+1)'(N))
                    - $signed({1'b0, lz});
  assign nxt_data   = work[2*N-1:N];
  assign nxt_shift  = N'(shift_s);
  assign unused_low = ^work[N-1:0];
`endif

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      lz        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            lz   <= '0;
            if (in_data == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_zero  <= 1'b1;
              out_data  <= '0;
              out_shift <= '0;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (work[2*N-1]) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_zero  <= 1'b0;
            out_data  <= nxt_data;
            out_shift <= nxt_shift;
          end else if (lz < LZ_W'(2*N-1)) begin
            work <= work << 1;
            lz   <= lz + LZ_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
